// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants used by fetch and decode.
//   NB_DATA         : instruction word width
//   NB_OPCODE       : opcode field width
//   OPCODE_POSITION : MSB of the opcode field
//   HALT_OPCODE     : opcode that stops fetch
//   NOP_INSTR       : encoding of a pipeline bubble
package mips_pkg;

  localparam int unsigned NB_DATA         = 32;
  localparam int unsigned NB_OPCODE       = 6;
  localparam int unsigned OPCODE_POSITION = NB_DATA - 1;
  localparam logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111;
  localparam logic [NB_DATA-1:0]   NOP_INSTR   = '0;

  // Fetch is either streaming instructions or parked after a HALT.
  typedef enum logic {
    ST_FETCH,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: ROM_DEPTH x NB_DATA array.
// Ports:
//   i_clock   : write clock
//   i_wr_en   : write strobe, takes effect at the rising edge
//   i_wr_addr : write word address
//   i_wr_data : write data
//   i_rd_addr : asynchronous read address
//   o_rd_data : word at i_rd_addr (pre-edge contents on a same-cycle write)
module instruction_memory #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned ROM_DEPTH = 1024,
  parameter int unsigned NB_PC     = 10
) (
  input  logic               i_clock,
  input  logic               i_wr_en,
  input  logic [NB_PC-1:0]   i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_PC-1:0]   i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  logic [NB_DATA-1:0] mem_q [ROM_DEPTH];

  // No reset: program contents survive a pipeline reset.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC and instruction
// memory and drives the IF/ID register.
// Ports:
//   i_clock, i_reset    : clock, synchronous active-high reset
//   i_enable            : debug run/step gate (0 freezes PC and IF/ID)
//   i_stall             : load-use stall, holds PC and IF/ID
//   i_branch_taken      : redirect to i_branch_target, flushes IF/ID
//   i_load_*            : instruction memory program-load write port
//   o_pipeline_if_id    : latched instruction
//   o_pc_stage_0        : PC+1 of the latched instruction
//   o_valid             : IF/ID holds a real instruction
//   o_halt_pending      : HALT fetched, fetch stopped
//   o_pc                : current fetch PC
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned ROM_DEPTH = 1024,
  parameter int unsigned NB_PC     = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_PC-1:0]   i_branch_target,
  input  logic               i_load_wr,
  input  logic [NB_PC-1:0]   i_load_addr,
  input  logic [NB_DATA-1:0] i_load_data,
  output logic [NB_DATA-1:0] o_pipeline_if_id,
  output logic [NB_PC-1:0]   o_pc_stage_0,
  output logic               o_valid,
  output logic               o_halt_pending,
  output logic [NB_PC-1:0]   o_pc
);

  logic [NB_PC-1:0]   pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_PC-1:0]   pc_next_q, pc_next_d;
  logic               valid_q, valid_d;
  fetch_state_t       state_q, state_d;
  logic [NB_DATA-1:0] mem_rd_data;
  logic [NB_PC-1:0]   pc_inc;

  instruction_memory #(
    .NB_DATA   (NB_DATA),
    .ROM_DEPTH (ROM_DEPTH),
    .NB_PC     (NB_PC)
  ) u_imem (
    .i_clock   (i_clock),
    .i_wr_en   (i_load_wr),
    .i_wr_addr (i_load_addr),
    .i_wr_data (i_load_data),
    .i_rd_addr (pc_q),
    .o_rd_data (mem_rd_data)
  );

  // Natural NB_PC-bit overflow gives the ROM_DEPTH-1 -> 0 wrap.
  assign pc_inc = pc_q + 1'b1;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q      <= '0;
      instr_q   <= NB_DATA'(NOP_INSTR);
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      state_q   <= ST_FETCH;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    state_d   = state_q;
    if (i_enable) begin
      if (i_branch_taken) begin
        // Redirect beats stall and cancels any wrong-path HALT.
        pc_d    = i_branch_target;
        instr_d = NB_DATA'(NOP_INSTR);
        valid_d = 1'b0;
        state_d = ST_FETCH;
      end else if (!i_stall) begin
        if (state_q == ST_HALT) begin
          instr_d = NB_DATA'(NOP_INSTR);
          valid_d = 1'b0;
        end else begin
          instr_d   = mem_rd_data;
          pc_next_d = pc_inc;
          valid_d   = 1'b1;
          pc_d      = pc_inc;
          if (mem_rd_data[NB_DATA-1 -: NB_OPCODE] == HALT_OPCODE) begin
            state_d = ST_HALT;
          end
        end
      end
    end
  end

  assign o_pipeline_if_id = instr_q;
  assign o_pc_stage_0     = pc_next_q;
  assign o_valid          = valid_q;
  assign o_halt_pending   = (state_q == ST_HALT);
  assign o_pc             = pc_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Owns the program counter and the instruction memory, and drives the IF/ID pipeline register consumed by instruction decode.
- Honours stall from the hazard unit, redirect from branch/jump resolution, run/step gating from the debug unit, and HALT detection.
- Provides a program-load write port so the debug unit can fill instruction memory.

Parameters:
- NB_DATA, 32, instruction/data word width.
- ROM_DEPTH, 1024, instruction memory depth in words (power of 2).
- NB_PC, 10, PC width in words; equals clog2(ROM_DEPTH).

Ports:
- i_clock  in  1  system clock, all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  debug run/step gate; 0 freezes PC and IF/ID.
- i_stall  in  1  hazard unit load-use stall; holds PC and IF/ID.
- i_branch_taken  in  1  redirect request from branch/jump resolution.
- i_branch_target  in  NB_PC  redirect word address.
- i_load_wr  in  1  instruction memory write strobe.
- i_load_addr  in  NB_PC  instruction memory write address.
- i_load_data  in  NB_DATA  instruction memory write data.
- o_pipeline_if_id  out  NB_DATA  latched instruction to decode.
- o_pc_stage_0  out  NB_PC  latched PC+1 of the instruction in IF/ID.
- o_valid  out  1  IF/ID holds a real instruction, not a bubble.
- o_halt_pending  out  1  HALT fetched; fetch stopped.
- o_pc  out  NB_PC  current fetch PC, for debug readout.

Behaviour:
- Reset (synchronous, wins over everything):
  - PC=0, o_pipeline_if_id=NOP (0), o_pc_stage_0=0, o_valid=0, o_halt_pending=0.
  - Memory contents are not cleared.
- Memory:
  - Asynchronous read at PC.
  - Synchronous write on i_load_wr, taking effect at the clock edge.
  - A same-cycle write to the address being fetched returns the OLD word; the new word is visible the next cycle.
  - Writes are accepted regardless of i_enable, stall or halt.
- Per-cycle priority, when not in reset:
  1. i_enable=0: PC, IF/ID and halt_pending hold.
  2. i_branch_taken=1:
     - PC <= i_branch_target.
     - IF/ID <= NOP with o_valid=0 (flush).
     - halt_pending <= 0.
     - Overrides i_stall and halt.
  3. i_stall=1: PC and IF/ID hold, o_valid holds.
  4. halt_pending=1: PC holds; IF/ID <= NOP with o_valid=0, one bubble per cycle.
  5. Normal fetch:
     - IF/ID <= mem[PC]; o_pc_stage_0 <= PC+1; o_valid=1; PC <= PC+1.
- Latency: a word at address A appears on o_pipeline_if_id one edge after PC=A with the stage advancing.
- HALT:
  - When a normal fetch latches an instruction whose opcode field [NB_DATA-1 -: 6] equals HALT_OPCODE (6'b111111), the HALT itself enters IF/ID (valid=1).
  - halt_pending is set and PC stays at A+1.
  - Only reset or a redirect clears it, so a wrong-path HALT is cancelled.
- Wrap-around: PC=ROM_DEPTH-1 increments to 0; o_pc_stage_0 wraps the same way.
- Width: i_branch_target is used as-is (NB_PC wide); no range check.
- Simultaneous redirect and stall: the redirect wins, since stall is only meaningful for the instruction being flushed.

Decomposition:
- Shared package mips_pkg:
  - NB_OPCODE=6, HALT_OPCODE=6'b111111, NOP_INSTR=32'h0.
  - OPCODE_POSITION = NB_DATA-1.
  - These are the same constants instruction_decode uses.
- Sub-module instruction_memory: ROM_DEPTH x NB_DATA array, one synchronous write port, one asynchronous read port.
- The PC/IF-ID control logic stays in instruction_fetch_unit.

Test Plan:
- Sequential fetch:
  - Stimulus: load mem[0..3]=32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'h0; release reset, enable=1.
  - Response: IF/ID shows the four words on consecutive cycles; o_pc_stage_0=1,2,3,4; o_valid=1 from the first edge.
- Stall:
  - Stimulus: assert i_stall 2 cycles while IF/ID holds the word at addr 1.
  - Response: IF/ID and o_pc stay at 32'h2002_0007 and 2; the word at addr 2 appears the cycle after release.
- Redirect:
  - Stimulus: at PC=3, pulse i_branch_taken with target=0x10 together with i_stall=1.
  - Response: next cycle IF/ID=NOP, o_valid=0, o_pc=0x10; next cycle IF/ID=mem[0x10], o_pc_stage_0=0x11.
- HALT:
  - Stimulus: mem[5]=32'hFC00_0000.
  - Response: after fetching it, o_halt_pending=1 and o_pc stays 6; subsequent IF/ID=NOP with valid=0 for 10 cycles.
  - Stimulus: then redirect to 0.
  - Response: halt_pending clears and fetch resumes at 0.
- Enable and load:
  - Stimulus: enable=0 for 3 cycles while writing mem[PC]=32'hAAAA_5555.
  - Response: outputs frozen; after enable=1 the new word is fetched.
  - Stimulus: write to the current PC with enable=1.
  - Response: the old word is latched that cycle.
- Wrap and reset:
  - Stimulus: redirect to 1023, advance 2 cycles.
  - Response: o_pc goes 1023 -> 0 -> 1.
  - Stimulus: assert i_reset mid-stall.
  - Response: all outputs at reset values next edge; memory contents preserved.
